apple_iie_video_scanner: RTL and testbench

APPLE_IIE_VIDEO_SCANNER -- requirements
Module: apple_iie_video_scanner

---
 rtl/apple_iie_video_scanner_if.sv | 22 ++
 rtl/apple_iie_video_scanner.sv | 85 ++++++++
 tb/tb_apple_iie_video_scanner.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/apple_iie_video_scanner_if.sv
// Soft-switch inputs and raster/address outputs of the Apple IIe video scanner.
// The scanner is the master: it drives the counters, syncs and fetch address.
interface apple_iie_video_scanner_if;
  logic        text_mode, hires, mixed, page2, store80;
  logic [6:0]  hcount;
  logic [8:0]  vcount;
  logic        hblank, vblank, hsync, vsync;
  logic [15:0] vid_addr;
  logic        vid_addr_valid;
  logic        frame_start;

  modport master (
    input  text_mode, hires, mixed, page2, store80,
    output hcount, vcount, hblank, vblank, hsync, vsync,
           vid_addr, vid_addr_valid, frame_start
  );
  modport slave (
    output text_mode, hires, mixed, page2, store80,
    input  hcount, vcount, hblank, vblank, hsync, vsync,
           vid_addr, vid_addr_valid, frame_start
  );
endinterface

// File: rtl/apple_iie_video_scanner.sv
// Apple IIe raster scanner: 65x262 H/V counters stepped on phi0_end, with
// blanking, sync and the text/lores/hires fetch address aligned to the counters.
module apple_iie_video_scanner #(
  parameter logic [8:0] VSTART = 9'h0FA
) (
  input  logic                        clk_14M,
  input  logic                        reset,
  input  logic                        phi0_end,
  apple_iie_video_scanner_if.master   vid
);

  logic [6:0]  h_nxt;
  logic [8:0]  v_nxt;
  logic        h_wrap, v_load;
  logic        hb_nxt, vb_nxt, valid_nxt;
  logic [7:0]  line;
  logic [4:0]  row;
  logic [15:0] col;
  logic        use_text, page;
  logic [15:0] txt_addr, hgr_addr, addr_nxt;

  // Everything is derived from the post-edge counter values so the address
  // registered on an edge matches the counters registered on the same edge.
  always_comb begin
    h_wrap = (vid.hcount == 7'h7F);
    v_load = h_wrap && (vid.vcount == 9'h1FF);
    if (vid.hcount == 7'h00) h_nxt = 7'h40;
    else if (h_wrap)         h_nxt = 7'h00;
    else                     h_nxt = vid.hcount + 7'd1;
    if (!h_wrap)     v_nxt = vid.vcount;
    else if (v_load) v_nxt = VSTART;
    else             v_nxt = vid.vcount + 9'd1;

    hb_nxt    = (h_nxt < 7'h58);
    vb_nxt    = (v_nxt < 9'h100) || (v_nxt >= 9'h1C0);
    valid_nxt = !(hb_nxt || vb_nxt);

    // Inside the visible window vcount is 0x100..0x1BF, so the low byte is L.
    line = v_nxt[7:0];
    row  = line[7:3];
    col  = {9'd0, h_nxt} - 16'h0058;

    use_text = vid.text_mode || (vid.mixed && (line >= 8'd160));
    page     = vid.page2 && !vid.store80;

    txt_addr = (page ? 16'h0800 : 16'h0400)
             + {6'd0, row[2:0], 7'd0}
             + ({14'd0, row[4:3]} * 16'd40)
             + col;
    hgr_addr = (page ? 16'h4000 : 16'h2000)
             + {3'd0, line[2:0], 10'd0}
             + {6'd0, line[5:3], 7'd0}
             + ({14'd0, line[7:6]} * 16'd40)
             + col;
    addr_nxt = (use_text || !vid.hires) ? txt_addr : hgr_addr;
  end

  always_ff @(posedge clk_14M) begin
    if (reset) begin
      vid.hcount         <= 7'h00;
      vid.vcount         <= VSTART;
      vid.frame_start    <= 1'b0;
      vid.vid_addr       <= 16'h0000;
      vid.hblank         <= 1'b1;
      vid.vblank         <= 1'b1;
      vid.hsync          <= 1'b0;
      vid.vsync          <= 1'b0;
      vid.vid_addr_valid <= 1'b0;
    end else begin
      // frame_start is a single clk_14M pulse, not a phi0-long level.
      vid.frame_start <= phi0_end && v_load;
      if (phi0_end) begin
        vid.hcount         <= h_nxt;
        vid.vcount         <= v_nxt;
        vid.hblank         <= hb_nxt;
        vid.vblank         <= vb_nxt;
        vid.hsync          <= (h_nxt >= 7'h49) && (h_nxt <= 7'h4C);
        vid.vsync          <= (v_nxt >= 9'h1E0) && (v_nxt <= 9'h1E3);
        vid.vid_addr_valid <= valid_nxt;
        if (valid_nxt) vid.vid_addr <= addr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_apple_iie_video_scanner.sv
// Directed bench for apple_iie_video_scanner: reset state, full-frame sweep,
// table of raster positions with hand-computed addresses, reset/switch corners.
module tb_apple_iie_video_scanner;
  logic clk_14M = 1'b0;
  logic reset = 1'b1;
  logic phi0_end = 1'b0;

  apple_iie_video_scanner_if vif();
  apple_iie_video_scanner #(.VSTART(9'h0FA)) dut (
    .clk_14M  (clk_14M),
    .reset    (reset),
    .phi0_end (phi0_end),
    .vid      (vif)
  );

  always #5 clk_14M = ~clk_14M;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [8:0]  v;
    logic [6:0]  h;
    logic [4:0]  sw;     // {text_mode, hires, mixed, page2, store80}
    logic [15:0] addr;
    logic        valid;
    logic        hb;
    logic        vb;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_sw(input logic [4:0] sw);
    {vif.text_mode, vif.hires, vif.mixed, vif.page2, vif.store80} = sw;
  endtask

  // phi0_end held high for n consecutive clocks; returns at a negedge.
  task automatic pulses(input int n);
    if (n > 0) begin
      @(negedge clk_14M) phi0_end = 1'b1;
      repeat (n) @(posedge clk_14M);
      @(negedge clk_14M) phi0_end = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk_14M) begin reset = 1'b1; phi0_end = 1'b0; end
    @(posedge clk_14M);
    @(negedge clk_14M) reset = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hcount"}, 32'(vif.hcount), 32'h00);
    chk({tag, "_vcount"}, 32'(vif.vcount), 32'h0FA);
    chk({tag, "_addr"},   32'(vif.vid_addr), 32'h0000);
    chk({tag, "_flags"},
        32'({vif.frame_start, vif.hblank, vif.vblank, vif.hsync, vif.vsync, vif.vid_addr_valid}),
        32'(6'b011000));
  endtask

  // phi0_end pulses from the reset state to reach raster position (v,h).
  function automatic int pos_of(input logic [8:0] v, input logic [6:0] h);
    return (int'(v) - 'h0FA) * 65 + ((h == 7'h00) ? 0 : int'(h) - 'h3F);
  endfunction

  initial begin
    logic [6:0] mh;
    logic [8:0] mv;
    int fs_cnt;
    int cur;

    tbl[0]  = '{9'h0FA, 7'h40, 5'b10000, 16'h0000, 1'b0, 1'b1, 1'b1};
    tbl[1]  = '{9'h100, 7'h57, 5'b10000, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[2]  = '{9'h100, 7'h58, 5'b10000, 16'h0400, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{9'h100, 7'h59, 5'b10000, 16'h0401, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{9'h100, 7'h7F, 5'b01000, 16'h2027, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{9'h101, 7'h00, 5'b01000, 16'h2027, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{9'h108, 7'h58, 5'b01010, 16'h4080, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{9'h140, 7'h58, 5'b10000, 16'h0428, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{9'h140, 7'h60, 5'b00010, 16'h0830, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{9'h1A0, 7'h58, 5'b01110, 16'h0A50, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{9'h1A1, 7'h58, 5'b01111, 16'h0650, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{9'h1A1, 7'h60, 5'b01000, 16'h2658, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{9'h1BF, 7'h7F, 5'b01000, 16'h3FF7, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{9'h1C0, 7'h00, 5'b01000, 16'h3FF7, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{9'h1C0, 7'h58, 5'b01000, 16'h3FF7, 1'b0, 1'b0, 1'b1};

    set_sw(5'b00000);
    repeat (2) @(posedge clk_14M);
    @(negedge clk_14M);
    chk_reset_vals("por");

    // Full frame with phi0_end held high; model checks counters and syncs.
    do_reset();
    mh = 7'h00; mv = 9'h0FA; fs_cnt = 0;
    @(negedge clk_14M) phi0_end = 1'b1;
    for (int i = 0; i < 17030; i++) begin
      @(posedge clk_14M); #1;
      if (mh == 7'h7F) begin
        mh = 7'h00;
        mv = (mv == 9'h1FF) ? 9'h0FA : mv + 9'd1;
      end else if (mh == 7'h00) mh = 7'h40;
      else mh = mh + 7'd1;
      chk("sweep_h_v_hs_vs", 32'({vif.hcount, vif.vcount, vif.hsync, vif.vsync}),
          32'({mh, mv, (mh >= 7'h49 && mh <= 7'h4C), (mv >= 9'h1E0 && mv <= 9'h1E3)}));
      if (vif.frame_start === 1'b1) fs_cnt++;
    end
    @(negedge clk_14M) phi0_end = 1'b0;
    chk("frame_hcount", 32'(vif.hcount), 32'h00);
    chk("frame_vcount", 32'(vif.vcount), 32'h0FA);
    chk("frame_start_count", 32'(fs_cnt), 32'd1);
    chk("frame_start_now", 32'(vif.frame_start), 32'd1);
    @(posedge clk_14M); #1;
    chk("frame_start_clear", 32'(vif.frame_start), 32'd0);
    chk("hold_no_phi0", 32'(vif.hcount), 32'h00);

    // Table of raster positions, walked forward in one frame.
    do_reset();
    cur = 0;
    foreach (tbl[i]) begin
      set_sw(tbl[i].sw);
      pulses(pos_of(tbl[i].v, tbl[i].h) - cur);
      cur = pos_of(tbl[i].v, tbl[i].h);
      chk($sformatf("vec%0d_pos", i), 32'({vif.vcount, vif.hcount}), 32'({tbl[i].v, tbl[i].h}));
      chk($sformatf("vec%0d_addr", i), 32'(vif.vid_addr), 32'(tbl[i].addr));
      chk($sformatf("vec%0d_flags", i), 32'({vif.vid_addr_valid, vif.hblank, vif.vblank}),
          32'({tbl[i].valid, tbl[i].hb, tbl[i].vb}));
    end

    // Soft switch change between phi0_end strobes must not disturb the address.
    do_reset();
    set_sw(5'b10000);
    pulses(pos_of(9'h150, 7'h58));
    chk("sw_base_addr", 32'(vif.vid_addr), 32'h0528);
    vif.page2 = 1'b1;
    repeat (2) @(negedge clk_14M);
    chk("sw_midcycle_hold", 32'(vif.vid_addr), 32'h0528);
    pulses(1);
    chk("sw_next_phi0", 32'(vif.vid_addr), 32'h0929);

    // Reset beats phi0_end on the same edge, mid-frame.
    @(negedge clk_14M) begin reset = 1'b1; phi0_end = 1'b1; end
    @(posedge clk_14M);
    @(negedge clk_14M) begin reset = 1'b0; phi0_end = 1'b0; end
    chk_reset_vals("midrst");
    pulses(1);
    chk("midrst_first_h", 32'(vif.hcount), 32'h40);
    chk("midrst_first_v", 32'(vif.vcount), 32'h0FA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
